id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 160 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand select, write-back bypass, load-use stall detection
// and saturating stall/bubble performance counters.
module id_ex_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [4:0]  id_rd,
   input  logic [31:0] id_imm,
   input  logic [7:0]  id_ctrl,
   input  logic [31:0] rdata1,
   input  logic [31:0] rdata2,
   input  logic        wb_regwrite,
   input  logic [4:0]  wb_reg,
   input  logic [31:0] wb_data,
   input  logic        flush,
   output logic        stall,
   output logic        ex_valid,
   output logic [4:0]  ex_rs,
   output logic [4:0]  ex_rt,
   output logic [4:0]  ex_dst,
   output logic [31:0] ex_a,
   output logic [31:0] ex_b,
   output logic [31:0] ex_imm,
   output logic [7:0]  ex_ctrl,
   output logic [15:0] stall_cnt,
   output logic [15:0] bubble_cnt
);

   logic        r_ex_valid;
   logic [4:0]  r_ex_rs;
   logic [4:0]  r_ex_rt;
   logic [4:0]  r_ex_dst;
   logic [31:0] r_ex_a;
   logic [31:0] r_ex_b;
   logic [31:0] r_ex_imm;
   logic [7:0]  r_ex_ctrl;
   logic [15:0] r_stall_cnt;
   logic [15:0] r_bubble_cnt;

   logic        w_hazard;
   logic        w_stall;
   logic        w_bubble;
   logic        w_forced_bubble;
   logic [31:0] w_op_a;
   logic [31:0] w_op_b;
   logic [4:0]  w_dst;

   logic        w_ex_valid_nxt;
   logic [4:0]  w_ex_rs_nxt;
   logic [4:0]  w_ex_rt_nxt;
   logic [4:0]  w_ex_dst_nxt;
   logic [31:0] w_ex_a_nxt;
   logic [31:0] w_ex_b_nxt;
   logic [31:0] w_ex_imm_nxt;
   logic [7:0]  w_ex_ctrl_nxt;
   logic [15:0] w_stall_cnt_nxt;
   logic [15:0] w_bubble_cnt_nxt;

   // A bubble in EX has ex_ctrl=0, so the retry cycle can never re-detect the hazard.
   assign w_hazard = id_valid & r_ex_valid & r_ex_ctrl[1] & (r_ex_dst != 5'd0) &
                     ((r_ex_dst == id_rs) | (r_ex_dst == id_rt));
   assign w_stall  = w_hazard & ~flush;
   assign stall    = w_stall;

   assign w_forced_bubble = flush | w_stall;
   assign w_bubble        = w_forced_bubble | ~id_valid;

   assign w_dst = id_ctrl[4] ? id_rd : id_rt;

   // Register 0 reads as zero; otherwise the same-cycle write-back wins over the file.
   always_comb begin
      w_op_a = rdata1;
      if (id_rs == 5'd0) begin
         w_op_a = 32'd0;
      end else if (wb_regwrite && (wb_reg == id_rs)) begin
         w_op_a = wb_data;
      end
   end

   always_comb begin
      w_op_b = rdata2;
      if (id_rt == 5'd0) begin
         w_op_b = 32'd0;
      end else if (wb_regwrite && (wb_reg == id_rt)) begin
         w_op_b = wb_data;
      end
   end

   always_comb begin
      w_ex_valid_nxt = 1'b0;
      w_ex_rs_nxt    = 5'd0;
      w_ex_rt_nxt    = 5'd0;
      w_ex_dst_nxt   = 5'd0;
      w_ex_a_nxt     = 32'd0;
      w_ex_b_nxt     = 32'd0;
      w_ex_imm_nxt   = 32'd0;
      w_ex_ctrl_nxt  = 8'd0;
      if (!w_bubble) begin
         w_ex_valid_nxt = 1'b1;
         w_ex_rs_nxt    = id_rs;
         w_ex_rt_nxt    = id_rt;
         w_ex_dst_nxt   = w_dst;
         w_ex_a_nxt     = w_op_a;
         w_ex_b_nxt     = w_op_b;
         w_ex_imm_nxt   = id_imm;
         w_ex_ctrl_nxt  = id_ctrl;
      end
   end

   always_comb begin
      w_stall_cnt_nxt  = r_stall_cnt;
      w_bubble_cnt_nxt = r_bubble_cnt;
      if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
         w_stall_cnt_nxt = r_stall_cnt + 16'd1;
      end
      if (w_forced_bubble && (r_bubble_cnt != 16'hFFFF)) begin
         w_bubble_cnt_nxt = r_bubble_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex_valid   <= 1'b0;
         r_ex_rs      <= 5'd0;
         r_ex_rt      <= 5'd0;
         r_ex_dst     <= 5'd0;
         r_ex_a       <= 32'd0;
         r_ex_b       <= 32'd0;
         r_ex_imm     <= 32'd0;
         r_ex_ctrl    <= 8'd0;
         r_stall_cnt  <= 16'd0;
         r_bubble_cnt <= 16'd0;
      end else begin
         r_ex_valid   <= w_ex_valid_nxt;
         r_ex_rs      <= w_ex_rs_nxt;
         r_ex_rt      <= w_ex_rt_nxt;
         r_ex_dst     <= w_ex_dst_nxt;
         r_ex_a       <= w_ex_a_nxt;
         r_ex_b       <= w_ex_b_nxt;
         r_ex_imm     <= w_ex_imm_nxt;
         r_ex_ctrl    <= w_ex_ctrl_nxt;
         r_stall_cnt  <= w_stall_cnt_nxt;
         r_bubble_cnt <= w_bubble_cnt_nxt;
      end
   end

   assign ex_valid   = r_ex_valid;
   assign ex_rs      = r_ex_rs;
   assign ex_rt      = r_ex_rt;
   assign ex_dst     = r_ex_dst;
   assign ex_a       = r_ex_a;
   assign ex_b       = r_ex_b;
   assign ex_imm     = r_ex_imm;
   assign ex_ctrl    = r_ex_ctrl;
   assign stall_cnt  = r_stall_cnt;
   assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: inputs change on the falling edge,
// outputs are checked on the falling edge after each rising edge.
module tb_id_ex_stage;

   logic        clk;
   logic        rst_n;
   logic        id_valid;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic [4:0]  id_rd;
   logic [31:0] id_imm;
   logic [7:0]  id_ctrl;
   logic [31:0] rdata1;
   logic [31:0] rdata2;
   logic        wb_regwrite;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;
   logic        flush;
   logic        stall;
   logic        ex_valid;
   logic [4:0]  ex_rs;
   logic [4:0]  ex_rt;
   logic [4:0]  ex_dst;
   logic [31:0] ex_a;
   logic [31:0] ex_b;
   logic [31:0] ex_imm;
   logic [7:0]  ex_ctrl;
   logic [15:0] stall_cnt;
   logic [15:0] bubble_cnt;

   int n_checks = 0;
   int n_errors = 0;

   id_ex_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_rd       (id_rd),
      .id_imm      (id_imm),
      .id_ctrl     (id_ctrl),
      .rdata1      (rdata1),
      .rdata2      (rdata2),
      .wb_regwrite (wb_regwrite),
      .wb_reg      (wb_reg),
      .wb_data     (wb_data),
      .flush       (flush),
      .stall       (stall),
      .ex_valid    (ex_valid),
      .ex_rs       (ex_rs),
      .ex_rt       (ex_rt),
      .ex_dst      (ex_dst),
      .ex_a        (ex_a),
      .ex_b        (ex_b),
      .ex_imm      (ex_imm),
      .ex_ctrl     (ex_ctrl),
      .stall_cnt   (stall_cnt),
      .bubble_cnt  (bubble_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [7:0] ctrl,
                           input logic [31:0] imm);
      id_valid = v;
      id_rs    = rs;
      id_rt    = rt;
      id_rd    = rd;
      id_ctrl  = ctrl;
      id_imm   = imm;
   endtask

   initial begin
      rst_n       = 1'b0;
      wb_regwrite = 1'b0;
      wb_reg      = 5'd0;
      wb_data     = 32'd0;
      flush       = 1'b0;
      rdata1      = 32'd0;
      rdata2      = 32'd0;
      drive_id(1'b0, 5'd0, 5'd0, 5'd0, 8'h00, 32'd0);

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
      chk("rst_ex_ctrl", {24'd0, ex_ctrl}, 32'd0);
      chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
      chk("rst_bubble_cnt", {16'd0, bubble_cnt}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      rst_n = 1'b1;

      // Normal issue with RegDst=1
      rdata1 = 32'h11;
      rdata2 = 32'h22;
      drive_id(1'b1, 5'd3, 5'd4, 5'd9, 8'h11, 32'h1234);
      #1 chk("norm_stall", {31'd0, stall}, 32'd0);
      step();
      chk("norm_ex_a", ex_a, 32'h11);
      chk("norm_ex_b", ex_b, 32'h22);
      chk("norm_ex_dst", {27'd0, ex_dst}, 32'd9);
      chk("norm_ex_valid", {31'd0, ex_valid}, 32'd1);
      chk("norm_ex_ctrl", {24'd0, ex_ctrl}, 32'h11);
      chk("norm_ex_imm", ex_imm, 32'h1234);
      chk("norm_ex_rs", {27'd0, ex_rs}, 32'd3);
      chk("norm_ex_rt", {27'd0, ex_rt}, 32'd4);

      // RegDst=0 selects rt
      drive_id(1'b1, 5'd3, 5'd4, 5'd9, 8'h01, 32'h0);
      step();
      chk("regdst0_ex_dst", {27'd0, ex_dst}, 32'd4);

      // Load-use on rs: lw writes r5, next instruction reads r5
      drive_id(1'b1, 5'd1, 5'd5, 5'd0, 8'h0B, 32'h4);
      step();
      chk("lw_ex_dst", {27'd0, ex_dst}, 32'd5);
      drive_id(1'b1, 5'd5, 5'd6, 5'd7, 8'h11, 32'h0);
      #1 chk("lu_stall", {31'd0, stall}, 32'd1);
      step();
      chk("lu_ex_valid", {31'd0, ex_valid}, 32'd0);
      chk("lu_ex_ctrl", {24'd0, ex_ctrl}, 32'd0);
      chk("lu_ex_dst", {27'd0, ex_dst}, 32'd0);
      chk("lu_ex_a", ex_a, 32'd0);
      chk("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
      chk("lu_bubble_cnt", {16'd0, bubble_cnt}, 32'd1);
      chk("lu_retry_stall", {31'd0, stall}, 32'd0);
      step();
      chk("lu_issue_valid", {31'd0, ex_valid}, 32'd1);
      chk("lu_issue_dst", {27'd0, ex_dst}, 32'd7);
      chk("lu_issue_stall_cnt", {16'd0, stall_cnt}, 32'd1);

      // Load-use on rt combined with flush: flush wins, no stall counted
      drive_id(1'b1, 5'd1, 5'd8, 5'd0, 8'h0B, 32'h0);
      step();
      drive_id(1'b1, 5'd2, 5'd8, 5'd3, 8'h11, 32'h0);
      #1 chk("rt_hazard_stall", {31'd0, stall}, 32'd1);
      flush = 1'b1;
      #1 chk("flush_hz_stall", {31'd0, stall}, 32'd0);
      step();
      flush = 1'b0;
      chk("flush_hz_ex_valid", {31'd0, ex_valid}, 32'd0);
      chk("flush_hz_stall_cnt", {16'd0, stall_cnt}, 32'd1);
      chk("flush_hz_bubble_cnt", {16'd0, bubble_cnt}, 32'd2);

      // lw targeting r0 never causes a hazard
      drive_id(1'b1, 5'd1, 5'd0, 5'd0, 8'h0B, 32'h0);
      step();
      drive_id(1'b1, 5'd0, 5'd0, 5'd3, 8'h11, 32'h0);
      #1 chk("r0_no_stall", {31'd0, stall}, 32'd0);

      // Hazard needs id_valid; invalid ID loads an uncounted bubble
      drive_id(1'b1, 5'd1, 5'd5, 5'd0, 8'h0B, 32'h0);
      step();
      drive_id(1'b0, 5'd5, 5'd5, 5'd3, 8'h11, 32'h0);
      #1 chk("novalid_stall", {31'd0, stall}, 32'd0);
      step();
      chk("novalid_ex_valid", {31'd0, ex_valid}, 32'd0);
      chk("novalid_bubble_cnt", {16'd0, bubble_cnt}, 32'd2);

      // Write-back bypass and zero register
      wb_regwrite = 1'b1;
      wb_reg      = 5'd7;
      wb_data     = 32'hDEAD;
      rdata1      = 32'h1;
      rdata2      = 32'h55;
      drive_id(1'b1, 5'd7, 5'd0, 5'd2, 8'h11, 32'h0);
      step();
      chk("byp_ex_a", ex_a, 32'hDEAD);
      chk("zero_ex_b", ex_b, 32'd0);
      drive_id(1'b1, 5'd0, 5'd7, 5'd2, 8'h11, 32'h0);
      step();
      chk("byp_ex_b", ex_b, 32'hDEAD);
      chk("zero_ex_a", ex_a, 32'd0);
      wb_regwrite = 1'b0;
      drive_id(1'b1, 5'd7, 5'd7, 5'd2, 8'h11, 32'h0);
      step();
      chk("nobyp_ex_a", ex_a, 32'h1);
      chk("nobyp_ex_b", ex_b, 32'h55);

      // Asynchronous reset between edges with ex_valid=1
      chk("pre_arst_valid", {31'd0, ex_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_ex_valid", {31'd0, ex_valid}, 32'd0);
      chk("arst_ex_a", ex_a, 32'd0);
      chk("arst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
      chk("arst_bubble_cnt", {16'd0, bubble_cnt}, 32'd0);
      step();
      chk("arst_hold_valid", {31'd0, ex_valid}, 32'd0);
      rst_n = 1'b1;
      step();
      chk("arst_resume_valid", {31'd0, ex_valid}, 32'd1);

      // bubble_cnt saturation via continuous flush
      flush = 1'b1;
      for (int i = 0; i < 65535; i++) @(posedge clk);
      @(negedge clk);
      chk("bsat_reach", {16'd0, bubble_cnt}, 32'hFFFF);
      for (int i = 0; i < 4; i++) @(posedge clk);
      @(negedge clk);
      chk("bsat_hold", {16'd0, bubble_cnt}, 32'hFFFF);
      chk("bsat_stall_cnt", {16'd0, stall_cnt}, 32'd0);
      flush = 1'b0;

      // stall_cnt saturation: preload near the top, then real load-use stalls
      force dut.r_stall_cnt = 16'hFFFD;
      #1 release dut.r_stall_cnt;
      for (int k = 0; k < 3; k++) begin
         drive_id(1'b1, 5'd1, 5'd5, 5'd0, 8'h0B, 32'h0);
         step();
         drive_id(1'b1, 5'd5, 5'd6, 5'd7, 8'h11, 32'h0);
         step();
         case (k)
            0: chk("ssat_fffe", {16'd0, stall_cnt}, 32'hFFFE);
            1: chk("ssat_reach", {16'd0, stall_cnt}, 32'hFFFF);
            default: chk("ssat_hold", {16'd0, stall_cnt}, 32'hFFFF);
         endcase
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
